resonant_sys_ctrl: RTL and testbench
====================================

Name: resonant_sys_ctrl

Overview:
Sequencer for the resonant_sys emulation datapath. It accepts reference-current updates from a host over a valid/ready handshake, applies them to i_ref only at safe points, and drives start. It counts the q_serialized charge pulses over fixed measurement windows and reports the window charge (pulses × Q_PER_PULSE) with a one-cycle valid strobe. It sits between the host/config logic and resonant_sys.

Parameters:
BUS_WIDTH, 10, width of i_ref and cfg_iref
PULSE_DURATION, 3, nominal q_serialized high time in clk cycles; used for width checking
Q_PER_PULSE, 60, charge units per pulse
WINDOW_CYCLES, 256, length of one measurement window in RUN, in clk cycles (≥2)
SETTLE_CYCLES, 4, cycles start is held low after i_ref changes (≥1)
CNT_WIDTH, 16, width of the pulse and charge result buses

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; run measurement while high
cfg_valid  in  1  new reference offered
cfg_ready  out  1  shadow register empty; transfer occurs when cfg_valid && cfg_ready
cfg_iref  in  BUS_WIDTH  requested reference
i_ref  out  BUS_WIDTH  reference to resonant_sys
start  out  1  run request to resonant_sys
q_serialized  in  1  pulse stream from resonant_sys, synchronous to clk
meas_valid  out  1  one-cycle strobe: result buses valid
meas_pulses  out  CNT_WIDTH  rising edges counted in the last window
meas_charge  out  CNT_WIDTH  meas_pulses × Q_PER_PULSE, saturated
pulse_err  out  1  sticky: a q_serialized high run exceeded PULSE_DURATION cycles
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; i_ref=0, start=0, cfg_ready=1, meas_valid=0, meas_pulses=0, meas_charge=0, pulse_err=0, shadow empty, all counters 0, q_d=0.
- Shadow register: a transfer loads cfg_iref into the shadow and sets pending. cfg_ready = !pending and is registered. A transfer is accepted in any state, including during a window. pending clears on LOAD entry.
- FSM states: IDLE, LOAD, RUN, REPORT.
- IDLE: start=0. When enable=1, go to LOAD.
- LOAD: on the entry cycle, if pending, i_ref<=shadow; otherwise i_ref is unchanged. start=0. Clears pulse_err and the pulse counter. Stays SETTLE_CYCLES cycles, then goes to RUN.
- RUN: start=1 (registered, so it rises on the first RUN cycle). Window counter runs 0..WINDOW_CYCLES-1. After the last cycle, go to REPORT.
- REPORT: meas_valid=1 for exactly this cycle, with meas_pulses/meas_charge holding the window result. start stays 1. Next state:
  - enable=0 → IDLE
  - pending → LOAD (start drops)
  - otherwise → RUN (new window; pulse counter cleared, start stays high, no gap).
- Pulse counting: rising edge = q_serialized && !q_d. An edge is counted only when it is detected in a RUN cycle; edges in LOAD, REPORT or IDLE are ignored. The counter saturates at 2^CNT_WIDTH-1.
- Charge: computed from the final count with a CNT_WIDTH+8 bit product, saturated to all-ones. Result buses hold their value between strobes.
- Width check: a high-run counter increments while q_serialized=1 and resets when it is 0. pulse_err sets when the run exceeds PULSE_DURATION cycles, in any state other than IDLE. It clears only on LOAD entry or reset.
- Enable falling mid-RUN or mid-LOAD: abort on the next clock to IDLE. start=0, no meas_valid, results not updated, shadow retained.
- Simultaneous cfg transfer and REPORT: the new value is pending in the same cycle, so REPORT → LOAD.
- Reset mid-operation: immediate return to reset values, and any pending shadow is discarded.

Test Plan:
- Reset with enable=1, cfg_iref=600 offered → after rst_n rises: cfg_ready=1, transfer, LOAD; i_ref=600; start rises 4 cycles later.
- WINDOW_CYCLES=256, 3-cycle pulses every 20 cycles in RUN → meas_valid once per 257 cycles; meas_pulses=13, meas_charge=780; start never drops between windows.
- During a window, offer cfg_iref=1000 → cfg_ready low until LOAD. i_ref stays 600 until after REPORT, then becomes 1000. start is low 4 cycles.
- Second cfg offered while pending → cfg_valid held, not accepted until LOAD entry. Single extra transfer, no value lost.
- q_serialized held high 5 cycles → pulse_err=1 from cycle 4 of the high run, counted as 1 pulse, cleared at next LOAD.
- Drop enable at window cycle 100 → IDLE next cycle, start=0, no meas_valid, results unchanged. Re-raising enable → LOAD with i_ref unchanged.
- Q_PER_PULSE=60, 1200 pulses forced (small CNT_WIDTH override=16) → meas_charge=65535 saturated.

Source files
------------

// File: rtl/resonant_sys_ctrl.sv
// resonant_sys_ctrl: applies host reference updates to resonant_sys at safe points,
// drives start, and measures q_serialized charge pulses over fixed windows.
module resonant_sys_ctrl #(
  parameter int BUS_WIDTH      = 10,
  parameter int PULSE_DURATION = 3,
  parameter int Q_PER_PULSE    = 60,
  parameter int WINDOW_CYCLES  = 256,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [BUS_WIDTH-1:0] cfg_iref,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 start,
  input  logic                 q_serialized,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] meas_pulses,
  output logic [CNT_WIDTH-1:0] meas_charge,
  output logic                 pulse_err,
  output logic                 busy
);

  localparam int CYC_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int HI_W    = $clog2(PULSE_DURATION + 1);
  localparam int PROD_W  = CNT_WIDTH + 8;

  localparam logic [CYC_W-1:0]     SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]     WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CYC_W-1:0]     CYC_ONE     = CYC_W'(1);
  localparam logic [HI_W-1:0]      HI_LIMIT    = HI_W'(PULSE_DURATION);
  localparam logic [HI_W-1:0]      HI_ONE      = HI_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [PROD_W-1:0]    Q_MULT      = PROD_W'(Q_PER_PULSE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_charge(input logic [CNT_WIDTH-1:0] cnt);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(cnt) * Q_MULT;
    if (|prod[PROD_W-1:CNT_WIDTH]) begin
      return CNT_MAX;
    end else begin
      return prod[CNT_WIDTH-1:0];
    end
  endfunction

  state_t                 state_r, state_s;
  logic [CYC_W-1:0]       cyc_cnt_r;
  logic [HI_W-1:0]        hi_cnt_r;
  logic                   q_d_r;
  logic                   pending_r;
  logic [BUS_WIDTH-1:0]   shadow_r;
  logic [BUS_WIDTH-1:0]   i_ref_r;
  logic                   cfg_ready_r;
  logic                   start_r;
  logic                   busy_r;
  logic                   meas_valid_r;
  logic [CNT_WIDTH-1:0]   pulse_cnt_r;
  logic [CNT_WIDTH-1:0]   meas_pulses_r;
  logic [CNT_WIDTH-1:0]   meas_charge_r;
  logic                   pulse_err_r;

  logic                   xfer_s;
  logic                   pend_eff_s;
  logic [BUS_WIDTH-1:0]   shadow_eff_s;
  logic                   rise_s;
  logic                   load_entry_s;
  logic                   too_long_s;
  logic [CNT_WIDTH-1:0]   cnt_final_s;

  assign cfg_ready   = cfg_ready_r;
  assign i_ref       = i_ref_r;
  assign start       = start_r;
  assign busy        = busy_r;
  assign meas_valid  = meas_valid_r;
  assign meas_pulses = meas_pulses_r;
  assign meas_charge = meas_charge_r;
  assign pulse_err   = pulse_err_r;

  // A transfer in this cycle already counts as pending, so REPORT can branch to LOAD on it.
  assign xfer_s       = cfg_valid & cfg_ready_r;
  assign pend_eff_s   = pending_r | xfer_s;
  assign shadow_eff_s = xfer_s ? cfg_iref : shadow_r;
  assign rise_s       = q_serialized & ~q_d_r;
  assign load_entry_s = (state_s == LOAD) && (state_r != LOAD);
  assign too_long_s   = q_serialized && (hi_cnt_r == HI_LIMIT);
  assign cnt_final_s  = ((state_r == RUN) && rise_s && (pulse_cnt_r != CNT_MAX)) ?
                        (pulse_cnt_r + CNT_ONE) : pulse_cnt_r;

  // Next-state selection; dropping enable aborts from any active state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_s = LOAD;
        else        state_s = IDLE;
      end
      LOAD: begin
        if (!enable)                         state_s = IDLE;
        else if (cyc_cnt_r == SETTLE_LAST)   state_s = RUN;
        else                                 state_s = LOAD;
      end
      RUN: begin
        if (!enable)                         state_s = IDLE;
        else if (cyc_cnt_r == WINDOW_LAST)   state_s = REPORT;
        else                                 state_s = RUN;
      end
      REPORT: begin
        if (!enable)         state_s = IDLE;
        else if (pend_eff_s) state_s = LOAD;
        else                 state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, per-state cycle counter and q_serialized history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cyc_cnt_r <= {CYC_W{1'b0}};
      q_d_r     <= 1'b0;
      hi_cnt_r  <= {HI_W{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || (state_r == IDLE)) cyc_cnt_r <= {CYC_W{1'b0}};
      else                                           cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
      q_d_r <= q_serialized;
      if (!q_serialized)              hi_cnt_r <= {HI_W{1'b0}};
      else if (hi_cnt_r != HI_LIMIT)  hi_cnt_r <= hi_cnt_r + HI_ONE;
      else                            hi_cnt_r <= hi_cnt_r;
    end
  end

  // Shadow register and reference application on LOAD entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= 1'b0;
      shadow_r    <= {BUS_WIDTH{1'b0}};
      cfg_ready_r <= 1'b1;
      i_ref_r     <= {BUS_WIDTH{1'b0}};
    end else begin
      shadow_r <= shadow_eff_s;
      if (load_entry_s) begin
        pending_r   <= 1'b0;
        cfg_ready_r <= 1'b1;
        if (pend_eff_s) i_ref_r <= shadow_eff_s;
        else            i_ref_r <= i_ref_r;
      end else begin
        pending_r   <= pend_eff_s;
        cfg_ready_r <= ~pend_eff_s;
      end
    end
  end

  // Pulse counting, window results, width error and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_r   <= {CNT_WIDTH{1'b0}};
      meas_valid_r  <= 1'b0;
      meas_pulses_r <= {CNT_WIDTH{1'b0}};
      meas_charge_r <= {CNT_WIDTH{1'b0}};
      pulse_err_r   <= 1'b0;
      start_r       <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (state_r == RUN) pulse_cnt_r <= cnt_final_s;
      else                pulse_cnt_r <= {CNT_WIDTH{1'b0}};
      meas_valid_r <= (state_s == REPORT);
      if (state_s == REPORT) begin
        meas_pulses_r <= cnt_final_s;
        meas_charge_r <= sat_charge(cnt_final_s);
      end
      if (load_entry_s)                         pulse_err_r <= 1'b0;
      else if ((state_r != IDLE) && too_long_s) pulse_err_r <= 1'b1;
      else                                      pulse_err_r <= pulse_err_r;
      start_r <= (state_s == RUN) || (state_s == REPORT);
      busy_r  <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_resonant_sys_ctrl.sv
// Randomised bench for resonant_sys_ctrl: a behavioural model tracks phases as
// cycle countdowns and predicts every output each cycle; a second instance covers charge saturation.
module tb_resonant_sys_ctrl;

  localparam int BW      = 10;
  localparam int PD      = 3;
  localparam int QPP     = 60;
  localparam int WIN     = 256;
  localparam int SETTLE  = 4;
  localparam int CW      = 16;
  localparam int WIN_B   = 2500;
  localparam int MAX_ERR = 40;
  localparam int CMAX    = 65535;

  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_RUN = 2, MD_REPORT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, cfg_valid, cfg_ready, start, q_serialized;
  logic          meas_valid, pulse_err, busy;
  logic [BW-1:0] cfg_iref, i_ref;
  logic [CW-1:0] meas_pulses, meas_charge;

  logic          enable_b, q_b, cfg_valid_b, cfg_ready_b, start_b, meas_valid_b, pulse_err_b, busy_b;
  logic [BW-1:0] cfg_iref_b, i_ref_b;
  logic [CW-1:0] meas_pulses_b, meas_charge_b;

  resonant_sys_ctrl #(.BUS_WIDTH(BW), .PULSE_DURATION(PD), .Q_PER_PULSE(QPP),
                      .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_iref(cfg_iref), .i_ref(i_ref), .start(start), .q_serialized(q_serialized),
    .meas_valid(meas_valid), .meas_pulses(meas_pulses), .meas_charge(meas_charge),
    .pulse_err(pulse_err), .busy(busy));

  resonant_sys_ctrl #(.BUS_WIDTH(BW), .PULSE_DURATION(PD), .Q_PER_PULSE(QPP),
                      .WINDOW_CYCLES(WIN_B), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_iref(cfg_iref_b), .i_ref(i_ref_b), .start(start_b), .q_serialized(q_b),
    .meas_valid(meas_valid_b), .meas_pulses(meas_pulses_b), .meas_charge(meas_charge_b),
    .pulse_err(pulse_err_b), .busy(busy_b));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  int m_mode, m_left, m_shadow, m_iref, m_cnt, m_hi, m_pulses, m_charge;
  bit m_pend, m_prev_q, m_err, m_valid;
  int offers[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MD_IDLE; m_left = 0; m_shadow = 0; m_iref = 0; m_cnt = 0; m_hi = 0;
    m_pulses = 0; m_charge = 0; m_pend = 0; m_prev_q = 0; m_err = 0; m_valid = 0;
  endtask

  task automatic compare_all();
    check_eq("start",       32'(start),       32'((m_mode == MD_RUN) || (m_mode == MD_REPORT)));
    check_eq("busy",        32'(busy),        32'(m_mode != MD_IDLE));
    check_eq("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
    check_eq("i_ref",       32'(i_ref),       32'(m_iref));
    check_eq("meas_valid",  32'(meas_valid),  32'(m_valid));
    check_eq("meas_pulses", 32'(meas_pulses), 32'(m_pulses));
    check_eq("meas_charge", 32'(meas_charge), 32'(m_charge));
    check_eq("pulse_err",   32'(pulse_err),   32'(m_err));
  endtask

  // Drives cfg from the offer queue, advances the model over one clock, then compares.
  task automatic step();
    bit en, q, xfer, pend_eff, rise, to_load;
    int sh_eff, v;
    en = enable;
    q  = q_serialized;
    if (offers.size() > 0) begin
      v = offers[0];
      cfg_valid = 1'b1;
      cfg_iref  = v[BW-1:0];
    end else begin
      cfg_valid = 1'b0;
      cfg_iref  = '0;
    end
    xfer     = cfg_valid && !m_pend;
    pend_eff = m_pend || xfer;
    sh_eff   = xfer ? int'(cfg_iref) : m_shadow;
    rise     = q && !m_prev_q;
    if (m_mode != MD_IDLE && q && (m_hi + 1 > PD)) m_err = 1;
    m_hi     = q ? m_hi + 1 : 0;
    m_prev_q = q;
    m_valid  = 0;
    to_load  = 0;
    case (m_mode)
      MD_IDLE: if (en) to_load = 1;
      MD_LOAD: begin
        if (!en) m_mode = MD_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin m_mode = MD_RUN; m_left = WIN; m_cnt = 0; end
        end
      end
      MD_RUN: begin
        if (rise && m_cnt < CMAX) m_cnt++;
        if (!en) m_mode = MD_IDLE;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_mode   = MD_REPORT;
            m_pulses = m_cnt;
            m_charge = (m_cnt * QPP > CMAX) ? CMAX : m_cnt * QPP;
            m_valid  = 1;
          end
        end
      end
      default: begin
        if (!en) m_mode = MD_IDLE;
        else if (pend_eff) to_load = 1;
        else begin m_mode = MD_RUN; m_left = WIN; m_cnt = 0; end
      end
    endcase
    if (to_load) begin
      m_mode = MD_LOAD; m_left = SETTLE; m_err = 0;
      if (pend_eff) m_iref = sh_eff;
      m_pend = 0;
    end else begin
      m_pend = pend_eff;
    end
    m_shadow = sh_eff;
    @(posedge clk);
    #1;
    if (xfer) void'(offers.pop_front());
    cyc++;
    compare_all();
  endtask

  initial begin
    bit first_seen, found, got_b;
    int burst_left, gap_left, dis_left;
    first_seen = 0; found = 0; got_b = 0; burst_left = 0; gap_left = 0; dis_left = 0;
    rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b1; cfg_iref = 10'd600; q_serialized = 1'b0;
    enable_b = 1'b0; q_b = 1'b0; cfg_valid_b = 1'b0; cfg_iref_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    offers.push_back(600);
    @(negedge clk);
    rst_n = 1'b1;

    // regular 3-cycle pulses every 20 cycles, with two reference updates
    for (int t = 0; t < 900 && n_errors < MAX_ERR; t++) begin
      q_serialized = ((t % 20) < 3);
      if (t == 300) offers.push_back(1000);
      if (t == 310) offers.push_back(700);
      step();
      if (m_valid && !first_seen) begin
        first_seen = 1;
        check_eq("win1_pulses", 32'(meas_pulses), 32'd13);
        check_eq("win1_charge", 32'(meas_charge), 32'd780);
      end
    end

    // over-long high runs: 5 and 4 cycles flag an error, 3 cycles does not
    for (int t = 0; t < 300 && n_errors < MAX_ERR; t++) begin
      q_serialized = (t >= 50 && t < 55) || (t >= 120 && t < 124) || (t >= 200 && t < 203);
      step();
      if (t == 49) check_eq("err_before_long", 32'(pulse_err), 32'd0);
      if (t == 60) check_eq("err_after_long",  32'(pulse_err), 32'd1);
    end

    // enable dropped at window cycle 100, then restored
    for (int t = 0; t < 600 && !found && n_errors < MAX_ERR; t++) begin
      q_serialized = ((t % 17) < 2);
      if (m_mode == MD_RUN && m_left == WIN - 100) begin
        found  = 1;
        enable = 1'b0;
      end
      step();
    end
    check_eq("drop_point_reached", 32'(found), 32'd1);
    check_eq("drop_start_low", 32'(start), 32'd0);
    for (int t = 0; t < 5; t++) step();
    enable = 1'b1;
    for (int t = 0; t < 40; t++) step();

    // randomised pulses, reference offers and enable drops
    for (int t = 0; t < 1500 && n_errors < MAX_ERR; t++) begin
      if (burst_left > 0) begin
        q_serialized = 1'b1; burst_left--;
      end else if (gap_left > 0) begin
        q_serialized = 1'b0; gap_left--;
      end else begin
        burst_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(1, 3));
        gap_left   = $urandom_range(1, 12);
        q_serialized = 1'b1; burst_left--;
      end
      if ($urandom_range(0, 149) == 0 && offers.size() < 3) offers.push_back(int'($urandom_range(0, 1023)));
      if (dis_left > 0) begin
        enable = 1'b0; dis_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        enable = 1'b0; dis_left = $urandom_range(1, 6);
      end else begin
        enable = 1'b1;
      end
      step();
    end

    // saturation: 1250 pulses x 60 exceeds the 16-bit charge bus
    enable = 1'b0; q_serialized = 1'b0; offers.delete();
    enable_b = 1'b1;
    for (int k = 0; k < WIN_B + 200 && !got_b && n_errors < MAX_ERR; k++) begin
      q_b = k[0];
      step();
      if (meas_valid_b) begin
        got_b = 1;
        check_eq("sat_pulses",    32'(meas_pulses_b), 32'd1250);
        check_eq("sat_charge",    32'(meas_charge_b), 32'd65535);
        check_eq("sat_pulse_err", 32'(pulse_err_b),   32'd0);
        check_eq("sat_start",     32'(start_b),       32'd1);
        check_eq("sat_busy",      32'(busy_b),        32'd1);
        check_eq("sat_cfg_ready", 32'(cfg_ready_b),   32'd1);
        check_eq("sat_i_ref",     32'(i_ref_b),       32'd0);
      end
    end
    check_eq("sat_report_seen", 32'(got_b), 32'd1);
    enable_b = 1'b0; q_b = 1'b0;

    // reset while a reference is pending discards it
    enable = 1'b1;
    for (int t = 0; t < 20; t++) step();
    offers.push_back(333);
    for (int t = 0; t < 3; t++) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    offers.delete();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 300 && n_errors < MAX_ERR; t++) begin
      q_serialized = ((t % 7) < 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
